// File: rtl/calc2_port_tagger.sv
// calc2_port_tagger
//   Request issuer that sits directly upstream of one CALC2 requester port.
//   It takes client operations over a valid/ready handshake and assigns each
//   one the lowest free of four tags. It then drives the two-cycle port
//   protocol: cmd+op1+tag first, then op2 with an idle command.
//   DUT responses retire their tag and are echoed to the client with that tag.
//   A tag left outstanding for TIMEOUT_CYCLES is retired with a timeout
//   response. A response carrying a tag that is not outstanding sets a
//   sticky error flag.
//
// Ports
//   c_clk, reset         clock, asynchronous active-low reset
//   req_*                client request handshake (cmd, op1, op2)
//   port_*_out           to CALC2 reqN_cmd_in / reqN_data_in / reqN_tag_in
//   port_*_in            from CALC2 out_respN / out_dataN / out_tagN
//   rsp_*                one-cycle result pulse to the client (11 = timeout)
//   tags_busy            outstanding-tag bitmap
//   spurious_err         sticky: response seen for a tag that was not busy

// Per-tag busy flag plus saturating age counter.
module calc2_port_tagger_slot #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic c_clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic busy,
    output logic expired
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    // set and clr never target the same slot in one cycle: set only hits a
    // free tag, clr only hits a busy one. set is still given precedence.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (set) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (clr) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (busy && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // An expired tag stays busy until a free response cycle retires it.
    assign expired = busy && (cnt == CNT_MAX);
endmodule

module calc2_port_tagger #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic [3:0]  port_cmd_out,
    output logic [31:0] port_data_out,
    output logic [1:0]  port_tag_out,
    input  logic [1:0]  port_resp_in,
    input  logic [31:0] port_data_in,
    input  logic [1:0]  port_tag_in,
    output logic        rsp_valid,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_tag,
    output logic [3:0]  tags_busy,
    output logic        spurious_err
);
    localparam int NUM_TAGS = 4;

    typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2} state_t;

    state_t             state;
    logic               active;     // low in reset and until the first edge after it
    logic [1:0]         cur_tag;
    logic [31:0]        op2_q;

    logic [NUM_TAGS-1:0] tag_set;
    logic [NUM_TAGS-1:0] tag_clr;
    logic [NUM_TAGS-1:0] tag_exp;
    logic [1:0]          free_tag;
    logic [1:0]          exp_tag;
    logic                exp_any;
    logic                resp_hit;
    logic                resp_spur;

    // Gated by 'active' so ready reads 0 throughout reset, without looking at
    // the reset pin combinationally.
    assign req_ready = active && (state == IDLE) && (tags_busy != 4'hF);

    assign resp_hit  = (port_resp_in != 2'b00) &&  tags_busy[port_tag_in];
    assign resp_spur = (port_resp_in != 2'b00) && !tags_busy[port_tag_in];
    assign exp_any   = |tag_exp;

    // Lowest-index search: scan from the top so the lowest match wins.
    always_comb begin
        free_tag = 2'd0;
        exp_tag  = 2'd0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!tags_busy[i]) free_tag = 2'(i);
            if (tag_exp[i])    exp_tag  = 2'(i);
        end
    end

    // The tag becomes busy at the end of the first port cycle.
    // A genuine response always beats a pending timeout for the clear slot.
    always_comb begin
        tag_set = '0;
        tag_clr = '0;
        if (state == ISSUE1) tag_set = 4'b0001 << cur_tag;
        if (resp_hit)        tag_clr = 4'b0001 << port_tag_in;
        else if (exp_any)    tag_clr = 4'b0001 << exp_tag;
    end

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_slot
        calc2_port_tagger_slot #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .CNT_W          (CNT_W)
        ) u_slot (
            .c_clk   (c_clk),
            .reset   (reset),
            .set     (tag_set[g]),
            .clr     (tag_clr[g]),
            .busy    (tags_busy[g]),
            .expired (tag_exp[g])
        );
    end

    // Issue FSM. Port outputs are registered: the values for a state are
    // loaded on the edge that enters it.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            active        <= 1'b0;
            cur_tag       <= 2'd0;
            op2_q         <= '0;
            port_cmd_out  <= 4'b0000;
            port_data_out <= '0;
            port_tag_out  <= 2'd0;
        end else begin
            active <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state         <= ISSUE1;
                        cur_tag       <= free_tag;
                        op2_q         <= req_op2;
                        port_cmd_out  <= req_cmd;
                        port_data_out <= req_op1;
                        port_tag_out  <= free_tag;
                    end
                end
                ISSUE1: begin
                    state         <= ISSUE2;
                    port_cmd_out  <= 4'b0000;
                    port_data_out <= op2_q;
                    port_tag_out  <= cur_tag;
                end
                default: begin
                    state         <= IDLE;
                    port_cmd_out  <= 4'b0000;
                    port_data_out <= '0;
                    port_tag_out  <= 2'd0;
                end
            endcase
        end
    end

    // Client response path: one registered pulse per retired tag.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            rsp_valid    <= 1'b0;
            rsp_resp     <= 2'b00;
            rsp_data     <= '0;
            rsp_tag      <= 2'd0;
            spurious_err <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_resp  <= 2'b00;
            rsp_data  <= '0;
            rsp_tag   <= 2'd0;
            if (resp_hit) begin
                rsp_valid <= 1'b1;
                rsp_resp  <= port_resp_in;
                rsp_data  <= port_data_in;
                rsp_tag   <= port_tag_in;
            end else if (exp_any) begin
                rsp_valid <= 1'b1;
                rsp_resp  <= 2'b11;
                rsp_tag   <= exp_tag;
            end
            // Also covers a response racing the set of its own tag in ISSUE1.
            if (resp_spur) spurious_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_calc2_port_tagger.sv
module tb_calc2_port_tagger;
    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } rsp_t;

    logic c_clk, reset;

    // main instance (default timeout)
    logic        req_valid, req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1, req_op2;
    logic [3:0]  port_cmd_out;
    logic [31:0] port_data_out;
    logic [1:0]  port_tag_out;
    logic [1:0]  port_resp_in;
    logic [31:0] port_data_in;
    logic [1:0]  port_tag_in;
    logic        rsp_valid;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_tag;
    logic [3:0]  tags_busy;
    logic        spurious_err;

    // short-timeout instance
    logic        t_req_valid, t_req_ready;
    logic [3:0]  t_req_cmd;
    logic [31:0] t_req_op1, t_req_op2;
    logic [3:0]  t_port_cmd_out;
    logic [31:0] t_port_data_out;
    logic [1:0]  t_port_tag_out;
    logic [1:0]  t_port_resp_in;
    logic [31:0] t_port_data_in;
    logic [1:0]  t_port_tag_in;
    logic        t_rsp_valid;
    logic [1:0]  t_rsp_resp;
    logic [31:0] t_rsp_data;
    logic [1:0]  t_rsp_tag;
    logic [3:0]  t_tags_busy;
    logic        t_spurious_err;

    int   vectors = 0;
    int   miscompares = 0;
    rsp_t exp_q[$];
    rsp_t exp_tq[$];
    rsp_t mon_e, mon_te;

    calc2_port_tagger dut (
        .c_clk(c_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_op1(req_op1), .req_op2(req_op2),
        .port_cmd_out(port_cmd_out), .port_data_out(port_data_out), .port_tag_out(port_tag_out),
        .port_resp_in(port_resp_in), .port_data_in(port_data_in), .port_tag_in(port_tag_in),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .tags_busy(tags_busy), .spurious_err(spurious_err)
    );

    calc2_port_tagger #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut_t (
        .c_clk(c_clk), .reset(reset),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_cmd(t_req_cmd),
        .req_op1(t_req_op1), .req_op2(t_req_op2),
        .port_cmd_out(t_port_cmd_out), .port_data_out(t_port_data_out), .port_tag_out(t_port_tag_out),
        .port_resp_in(t_port_resp_in), .port_data_in(t_port_data_in), .port_tag_in(t_port_tag_in),
        .rsp_valid(t_rsp_valid), .rsp_resp(t_rsp_resp), .rsp_data(t_rsp_data), .rsp_tag(t_rsp_tag),
        .tags_busy(t_tags_busy), .spurious_err(t_spurious_err)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    // Scoreboards: every client response pulse must match the next expected entry.
    always @(negedge c_clk) begin
        if (rsp_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: got resp=%b data=%0d tag=%0d, required no response", rsp_resp, rsp_data, rsp_tag);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_resp, rsp_data, rsp_tag} !== mon_e) begin
                    miscompares++;
                    $display("FAIL rsp_content: got resp=%b data=%0d tag=%0d, required resp=%b data=%0d tag=%0d",
                             rsp_resp, rsp_data, rsp_tag, mon_e.resp, mon_e.data, mon_e.tag);
                end
            end
        end
        if (t_rsp_valid === 1'b1) begin
            vectors++;
            if (exp_tq.size() == 0) begin
                miscompares++;
                $display("FAIL t_rsp_unexpected: got resp=%b data=%0d tag=%0d, required no response", t_rsp_resp, t_rsp_data, t_rsp_tag);
            end else begin
                mon_te = exp_tq.pop_front();
                if ({t_rsp_resp, t_rsp_data, t_rsp_tag} !== mon_te) begin
                    miscompares++;
                    $display("FAIL t_rsp_content: got resp=%b data=%0d tag=%0d, required resp=%b data=%0d tag=%0d",
                             t_rsp_resp, t_rsp_data, t_rsp_tag, mon_te.resp, mon_te.data, mon_te.tag);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    // Present one request and return in the ISSUE1 cycle.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL issue_ready_wait: got ready=%b, required 1", req_ready); end
        req_valid = 1'b1; req_cmd = c; req_op1 = a; req_op2 = b;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic t_issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (t_req_ready !== 1'b1 && n < 20) begin tick(); n++; end
        vectors++;
        if (t_req_ready !== 1'b1) begin miscompares++; $display("FAIL t_issue_ready_wait: got ready=%b, required 1", t_req_ready); end
        t_req_valid = 1'b1; t_req_cmd = c; t_req_op1 = a; t_req_op2 = b;
        tick();
        t_req_valid = 1'b0;
    endtask

    task automatic drive_resp(input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
        port_resp_in = r; port_data_in = d; port_tag_in = t;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 0; req_cmd = 0; req_op1 = 0; req_op2 = 0;
        port_resp_in = 0; port_data_in = 0; port_tag_in = 0;
        t_req_valid = 0; t_req_cmd = 0; t_req_op1 = 0; t_req_op2 = 0;
        t_port_resp_in = 0; t_port_data_in = 0; t_port_tag_in = 0;
        #3;
        vectors++; if (port_cmd_out !== 4'b0000) begin miscompares++; $display("FAIL reset_cmd: got %b, required 0000", port_cmd_out); end
        vectors++; if (tags_busy !== 4'b0000) begin miscompares++; $display("FAIL reset_busy: got %b, required 0000", tags_busy); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, required 0", req_ready); end
        vectors++; if (rsp_valid !== 1'b0 || spurious_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b/%b, required 0/0", rsp_valid, spurious_err); end
        repeat (2) @(posedge c_clk);
        #2 reset = 1'b1;
        tick();
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b, required 1", req_ready); end
        vectors++; if (t_req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_t_ready: got %b, required 1", t_req_ready); end
    endtask

    task automatic test_single_add();
        issue(4'b0001, 32'd5, 32'd7);
        vectors++; if ({port_cmd_out, port_data_out, port_tag_out} !== {4'b0001, 32'd5, 2'd0}) begin miscompares++;
            $display("FAIL add_cycle1: got cmd=%b data=%0d tag=%0d, required 0001/5/0", port_cmd_out, port_data_out, port_tag_out); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL add_ready_issue1: got %b, required 0", req_ready); end
        vectors++; if (tags_busy !== 4'b0000) begin miscompares++; $display("FAIL add_busy_issue1: got %b, required 0000", tags_busy); end
        tick();
        vectors++; if ({port_cmd_out, port_data_out, port_tag_out} !== {4'b0000, 32'd7, 2'd0}) begin miscompares++;
            $display("FAIL add_cycle2: got cmd=%b data=%0d tag=%0d, required 0000/7/0", port_cmd_out, port_data_out, port_tag_out); end
        vectors++; if (tags_busy !== 4'b0001) begin miscompares++; $display("FAIL add_busy_set: got %b, required 0001", tags_busy); end
        tick();
        vectors++; if ({port_cmd_out, port_data_out} !== {4'b0000, 32'd0}) begin miscompares++;
            $display("FAIL add_idle_out: got cmd=%b data=%0d, required 0000/0", port_cmd_out, port_data_out); end
        exp_q.push_back('{2'b01, 32'd12, 2'd0});
        drive_resp(2'b01, 32'd12, 2'd0);
        tick();
        drive_resp(2'b00, 32'd0, 2'd0);
        vectors++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'd0) begin miscompares++; $display("FAIL add_rsp: got valid=%b tag=%0d, required 1/0", rsp_valid, rsp_tag); end
        vectors++; if (tags_busy !== 4'b0000) begin miscompares++; $display("FAIL add_busy_clr: got %b, required 0000", tags_busy); end
        tick();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_rsp_pulse: got %b, required 0", rsp_valid); end
    endtask

    task automatic test_tag_exhaustion();
        logic [3:0] cmds [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            issue(cmds[i], 32'(100 + i), 32'(200 + i));
            vectors++; if ({port_cmd_out, port_data_out, port_tag_out} !== {cmds[i], 32'(100 + i), 2'(i)}) begin miscompares++;
                $display("FAIL exh_issue%0d: got cmd=%b data=%0d tag=%0d, required %b/%0d/%0d", i, port_cmd_out, port_data_out, port_tag_out, cmds[i], 100 + i, i); end
            tick(); tick();
        end
        vectors++; if (tags_busy !== 4'b1111) begin miscompares++; $display("FAIL exh_busy_full: got %b, required 1111", tags_busy); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL exh_ready_full: got %b, required 0", req_ready); end
        exp_q.push_back('{2'b01, 32'd123, 2'd2});
        drive_resp(2'b01, 32'd123, 2'd2);
        tick();
        drive_resp(2'b00, 32'd0, 2'd0);
        vectors++; if (tags_busy !== 4'b1011) begin miscompares++; $display("FAIL exh_busy_after_rsp: got %b, required 1011", tags_busy); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL exh_ready_after_rsp: got %b, required 1", req_ready); end
        issue(4'b0110, 32'd7, 32'd8);
        vectors++; if (port_tag_out !== 2'd2) begin miscompares++; $display("FAIL exh_reuse_tag: got %0d, required 2", port_tag_out); end
        tick(); tick();
    endtask

    task automatic test_out_of_order();
        int         tg [3] = '{3, 0, 1};
        logic [3:0] busy_exp = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{2'b01, 32'(1000 + tg[i]), 2'(tg[i])});
            drive_resp(2'b01, 32'(1000 + tg[i]), 2'(tg[i]));
            tick();
            busy_exp[tg[i]] = 1'b0;
            vectors++; if (rsp_valid !== 1'b1 || rsp_tag !== 2'(tg[i]) || tags_busy !== busy_exp) begin miscompares++;
                $display("FAIL ooo_%0d: got valid=%b tag=%0d busy=%b, required 1/%0d/%b", i, rsp_valid, rsp_tag, tags_busy, tg[i], busy_exp); end
        end
        exp_q.push_back('{2'b10, 32'hFFFF_FFFF, 2'd2});
        drive_resp(2'b10, 32'hFFFF_FFFF, 2'd2);
        tick();
        drive_resp(2'b00, 32'd0, 2'd0);
        vectors++; if (tags_busy !== 4'b0000) begin miscompares++; $display("FAIL ooo_drain: got %b, required 0000", tags_busy); end
        tick();
    endtask

    task automatic test_spurious();
        vectors++; if (spurious_err !== 1'b0) begin miscompares++; $display("FAIL spur_pre: got %b, required 0", spurious_err); end
        drive_resp(2'b01, 32'd55, 2'd2);
        tick();
        drive_resp(2'b00, 32'd0, 2'd0);
        vectors++; if (spurious_err !== 1'b1 || rsp_valid !== 1'b0 || tags_busy !== 4'b0000) begin miscompares++;
            $display("FAIL spur_set: got err=%b valid=%b busy=%b, required 1/0/0000", spurious_err, rsp_valid, tags_busy); end
        repeat (3) tick();
        vectors++; if (spurious_err !== 1'b1) begin miscompares++; $display("FAIL spur_sticky: got %b, required 1", spurious_err); end
    endtask

    task automatic test_reset_mid_issue();
        issue(4'b0001, 32'd10, 32'd20);
        tick(); tick();
        issue(4'b0010, 32'd30, 32'd40);
        vectors++; if (port_cmd_out !== 4'b0010 || tags_busy !== 4'b0001) begin miscompares++;
            $display("FAIL rmi_pre: got cmd=%b busy=%b, required 0010/0001", port_cmd_out, tags_busy); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (port_cmd_out !== 4'b0000 || port_data_out !== 32'd0) begin miscompares++;
            $display("FAIL rmi_port: got cmd=%b data=%0d, required 0000/0", port_cmd_out, port_data_out); end
        vectors++; if (tags_busy !== 4'b0000 || req_ready !== 1'b0 || spurious_err !== 1'b0) begin miscompares++;
            $display("FAIL rmi_state: got busy=%b ready=%b err=%b, required 0000/0/0", tags_busy, req_ready, spurious_err); end
        @(posedge c_clk);
        #2 reset = 1'b1;
        tick();
        issue(4'b0101, 32'd1, 32'd3);
        vectors++; if (port_tag_out !== 2'd0) begin miscompares++; $display("FAIL rmi_first_tag: got %0d, required 0", port_tag_out); end
    endtask

    // Entered in the ISSUE1 cycle for tag 0 left by test_reset_mid_issue.
    task automatic test_spurious_collision();
        vectors++; if (spurious_err !== 1'b0) begin miscompares++; $display("FAIL col_pre: got %b, required 0", spurious_err); end
        drive_resp(2'b01, 32'd5, 2'd0);
        tick();
        drive_resp(2'b00, 32'd0, 2'd0);
        vectors++; if (tags_busy !== 4'b0001 || spurious_err !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++;
            $display("FAIL col_set_wins: got busy=%b err=%b valid=%b, required 0001/1/0", tags_busy, spurious_err, rsp_valid); end
        tick();
        exp_q.push_back('{2'b10, 32'd77, 2'd0});
        drive_resp(2'b10, 32'd77, 2'd0);
        tick();
        drive_resp(2'b00, 32'd0, 2'd0);
        vectors++; if (tags_busy !== 4'b0000 || rsp_valid !== 1'b1) begin miscompares++;
            $display("FAIL col_retire: got busy=%b valid=%b, required 0000/1", tags_busy, rsp_valid); end
        tick();
    endtask

    task automatic test_timeout();
        t_issue(4'b0001, 32'd1, 32'd2);
        tick();
        vectors++; if (t_tags_busy !== 4'b0001) begin miscompares++; $display("FAIL to_busy_set: got %b, required 0001", t_tags_busy); end
        exp_tq.push_back('{2'b11, 32'd0, 2'd0});
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++; if (t_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL to_early_%0d: got valid=%b, required 0", k, t_rsp_valid); end
        end
        tick();
        vectors++; if (t_rsp_valid !== 1'b1 || t_rsp_resp !== 2'b11 || t_rsp_tag !== 2'd0 || t_tags_busy !== 4'b0000) begin miscompares++;
            $display("FAIL to_fire: got valid=%b resp=%b tag=%0d busy=%b, required 1/11/0/0000", t_rsp_valid, t_rsp_resp, t_rsp_tag, t_tags_busy); end
        tick();
    endtask

    task automatic test_timeout_priority();
        t_issue(4'b0001, 32'd3, 32'd4);
        tick(); tick();
        t_issue(4'b0010, 32'd5, 32'd6);
        vectors++; if (t_port_tag_out !== 2'd1) begin miscompares++; $display("FAIL top_tag1: got %0d, required 1", t_port_tag_out); end
        tick();
        vectors++; if (t_tags_busy !== 4'b0011) begin miscompares++; $display("FAIL top_busy: got %b, required 0011", t_tags_busy); end
        repeat (5) tick();
        exp_tq.push_back('{2'b01, 32'd99, 2'd1});
        exp_tq.push_back('{2'b11, 32'd0, 2'd0});
        t_port_resp_in = 2'b01; t_port_data_in = 32'd99; t_port_tag_in = 2'd1;
        tick();
        t_port_resp_in = 2'b00; t_port_data_in = 32'd0; t_port_tag_in = 2'd0;
        vectors++; if (t_rsp_valid !== 1'b1 || t_rsp_tag !== 2'd1 || t_tags_busy !== 4'b0001) begin miscompares++;
            $display("FAIL top_real_first: got valid=%b tag=%0d busy=%b, required 1/1/0001", t_rsp_valid, t_rsp_tag, t_tags_busy); end
        tick();
        vectors++; if (t_rsp_valid !== 1'b1 || t_rsp_resp !== 2'b11 || t_rsp_tag !== 2'd0 || t_tags_busy !== 4'b0000) begin miscompares++;
            $display("FAIL top_timeout_next: got valid=%b resp=%b tag=%0d busy=%b, required 1/11/0/0000", t_rsp_valid, t_rsp_resp, t_rsp_tag, t_tags_busy); end
        tick(); tick();
    endtask

    task automatic test_drain();
        vectors++; if (exp_q.size() != 0 || exp_tq.size() != 0) begin miscompares++;
            $display("FAIL drain: got %0d/%0d responses outstanding, required 0/0", exp_q.size(), exp_tq.size()); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_tag_exhaustion();
        test_out_of_order();
        test_spurious();
        test_reset_mid_issue();
        test_spurious_collision();
        test_timeout();
        test_timeout_priority();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/calc2_port_tagger.md
Name: calc2_port_tagger

Overview:
- Per-port request issuer placed directly upstream of one CALC2 requester port. Four instances feed ports 1–4.
- Accepts operations from a client over a valid/ready handshake.
- Allocates one of 4 tags and drives the two-cycle CALC2 request protocol: cmd+op1+tag, then op2.
- Retires tags on DUT responses and reports each result back to the client with its tag.
- Times out lost responses and flags responses carrying a non-outstanding tag.

Parameters:
- TIMEOUT_CYCLES, 64: cycles a tag may stay outstanding before forced retirement (range 2..127).
- CNT_W, 7: per-tag timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- c_clk, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: client request valid.
- req_ready, out, 1: block can accept a request.
- req_cmd, in, 4: operation; 0001 add, 0010 sub, 0101 shl, 0110 shr. Other codes are forwarded unchanged.
- req_op1, in, 32: first operand.
- req_op2, in, 32: second operand.
- port_cmd_out, out, 4: to reqN_cmd_in.
- port_data_out, out, 32: to reqN_data_in.
- port_tag_out, out, 2: to reqN_tag_in.
- port_resp_in, in, 2: from out_respN; 00 none, 01 success, 10 overflow/underflow/invalid.
- port_data_in, in, 32: from out_dataN.
- port_tag_in, in, 2: from out_tagN.
- rsp_valid, out, 1: one-cycle pulse; client has no backpressure.
- rsp_resp, out, 2: 01/10 as returned by the DUT; 11 = timeout.
- rsp_data, out, 32: result; 0 on timeout.
- rsp_tag, out, 2: tag being retired.
- tags_busy, out, 4: bit i set while tag i is outstanding.
- spurious_err, out, 1: sticky; a response arrived with a non-busy tag.

Behaviour:
- Reset (reset=0, async):
  - FSM to IDLE.
  - All outputs 0, including port_cmd_out=0000 (idle command), tags_busy=0000, spurious_err=0.
  - All timeout counters and the pending-timeout flag cleared.
  - In-flight issue is abandoned mid-operation.
  - Deassertion takes effect at the first c_clk edge after reset rises.
- FSM states: IDLE, ISSUE1, ISSUE2.
  - req_ready = (state==IDLE) && (tags_busy != 1111); combinational from registers only.
  - IDLE: on req_valid && req_ready, latch cmd/op1/op2, choose the lowest-numbered free tag T, go to ISSUE1.
  - ISSUE1 (registered outputs): port_cmd_out=cmd, port_data_out=op1, port_tag_out=T. tags_busy[T] is set at the end of this cycle. Go to ISSUE2.
  - ISSUE2: port_cmd_out=0000, port_data_out=op2, port_tag_out=T. Go to IDLE.
  - IDLE outputs: port_cmd_out=0000, port_data_out=0, port_tag_out=0.
  - Throughput: one request per 3 cycles. The first port cycle follows the accept edge.
- Response retirement:
  - Trigger: port_resp_in != 00 sampled while tags_busy[port_tag_in]=1.
  - Next cycle: rsp_valid=1 with registered resp/data/tag, and that busy bit is cleared.
- Spurious response: port_resp_in != 00 with the tag not busy.
  - Sets spurious_err; no rsp_valid; tags_busy unchanged.
  - If the same tag is being set in the same cycle (ISSUE1), the set wins and the response is still spurious.
  - spurious_err is cleared only by reset.
- Timeout:
  - Each busy tag's counter increments every cycle and saturates at TIMEOUT_CYCLES. The counter is cleared when the tag is set.
  - When a counter equals TIMEOUT_CYCLES and no genuine response is being reported that cycle: emit rsp_valid, rsp_resp=11, rsp_data=0, rsp_tag=i, and clear busy[i]. Lowest-index tag first if several expire.
  - A genuine response always has priority. Expired tags wait, one per free cycle.
  - A genuine response arriving for an already-expired but still-busy tag retires it normally (no timeout reported).
- The block does not inspect or validate req_cmd.

Test Plan:
- Single add: req cmd=0001, op1=5, op2=7, accepted at cycle 0.
  - Cycle 1: port cmd=0001, data=5, tag=0. Cycle 2: cmd=0000, data=7, tag=0.
  - DUT returns resp=01, data=12, tag=0 → one cycle later rsp_valid with 01/12/tag 0, and tags_busy returns to 0000.
- Tag exhaustion: four requests with no responses → tags 0,1,2,3 used in order, tags_busy=1111, req_ready=0.
  - Response on tag 2 → req_ready=1; the next request receives tag 2.
- Out-of-order completion: responses for tags 3,0,1 in consecutive cycles → three consecutive rsp_valid pulses with the same tags, and busy bits cleared in that order.
- Timeout with TIMEOUT_CYCLES=8: tag 0 issued, no response → rsp_valid with resp=11, data=0, tag=0 exactly 9 cycles after busy[0] sets (8 increments plus report).
  - Inject a real response on tag 1 in the expiry cycle → tag 1 is reported first, then the timeout one cycle later.
- Spurious: resp=01 on tag 2 with tags_busy=0000 → spurious_err=1 and stays 1; no rsp_valid.
- Reset mid-issue: assert reset during ISSUE1 → port_cmd_out=0000, tags_busy=0000, req_ready=0 immediately (asynchronously).
  - After release, the next request gets tag 0.
